// File: rtl/led_frame_scheduler.sv
// Frame scheduler for a WS2812B strand: paces frames, double-buffers the pixel RAM
// and hands pixels to the strand driver one handshake at a time.
module led_frame_scheduler #(
  parameter int NUM_LEDS        = 20,
  parameter int COLOR_WIDTH     = 8,
  parameter int CLOCK_SPEED     = 100_000_000,
  parameter int FRAME_PERIOD_US = 16667,
  parameter int RAM_LATENCY     = 2,
  localparam int IW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1,
  localparam int PW = 3 * COLOR_WIDTH
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   enable_in,
  input  logic                   frame_swap_in,
  output logic                   ram_rd_en_out,
  output logic [IW:0]            ram_addr_out,
  input  logic [PW-1:0]          ram_data_in,
  output logic [COLOR_WIDTH-1:0] drv_green_out,
  output logic [COLOR_WIDTH-1:0] drv_red_out,
  output logic [COLOR_WIDTH-1:0] drv_blue_out,
  output logic                   drv_valid_out,
  input  logic                   drv_ready_in,
  input  logic                   drv_idle_in,
  output logic                   drv_force_reset_out,
  output logic                   front_buf_out,
  output logic                   frame_done_out,
  output logic [15:0]            frame_count_out,
  output logic                   frame_overrun_out
);

  localparam longint FRAME_CYC_L =
    (longint'(FRAME_PERIOD_US) * longint'(CLOCK_SPEED)) / 64'sd1_000_000;
  localparam int FRAME_CYC = int'(FRAME_CYC_L);
  localparam int TW        = (FRAME_CYC > 1) ? $clog2(FRAME_CYC) : 1;
  localparam int WAIT_MAX  = (RAM_LATENCY > 2) ? RAM_LATENCY : 2;
  localparam int WW        = $clog2(WAIT_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_DRAIN} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic            r_enable_d;
  logic            r_force_reset;
  logic [TW-1:0]   r_timer;
  logic            r_tick_pending;
  logic            r_overrun;
  logic            r_swap_pending;
  logic            r_front;
  logic [IW-1:0]   r_idx;
  logic [WW-1:0]   r_wait;
  logic [PW-1:0]   r_pixel;
  logic [PW-1:0]   r_drv_pixel;
  logic [15:0]     r_frame_count;

  logic            w_enable_rise;
  logic            w_timer_wrap;
  logic            w_tick;
  logic            w_start;
  logic            w_last_pixel;
  logic            w_fetch_done;
  logic            w_rd_en;
  logic            w_issue;
  logic            w_frame_done;
  logic [PW-1:0]   w_drv_pixel;

  assign w_enable_rise = enable_in & ~r_enable_d;
  assign w_timer_wrap  = (r_timer == TW'(FRAME_CYC - 1));
  assign w_tick        = enable_in & ~w_enable_rise & w_timer_wrap;
  assign w_start       = (r_state == S_IDLE) & enable_in & r_tick_pending;
  assign w_last_pixel  = (r_idx == IW'(NUM_LEDS - 1));
  assign w_fetch_done  = (r_state == S_FETCH) & (r_wait == WW'(RAM_LATENCY));

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_state <= S_IDLE;
    else           r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_rd_en      = 1'b0;
    w_issue      = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      S_IDLE:  if (w_start) w_state_next = S_FETCH;
      S_FETCH: begin
        w_rd_en = (r_wait == '0);
        if (w_fetch_done) w_state_next = S_ISSUE;
      end
      S_ISSUE: if (drv_ready_in) begin
        w_issue      = 1'b1;
        w_state_next = w_last_pixel ? S_DRAIN : S_FETCH;
      end
      // The driver's idle flag still reflects the previous pixel for two cycles
      S_DRAIN: if ((r_wait == WW'(2)) && drv_idle_in) begin
        w_frame_done = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_enable_d     <= 1'b0;
      r_force_reset  <= 1'b0;
      r_timer        <= '0;
      r_tick_pending <= 1'b0;
      r_overrun      <= 1'b0;
      r_swap_pending <= 1'b0;
      r_front        <= 1'b0;
      r_idx          <= '0;
      r_wait         <= '0;
      r_pixel        <= '0;
      r_drv_pixel    <= '0;
      r_frame_count  <= '0;
    end else begin
      r_enable_d    <= enable_in;
      r_force_reset <= w_enable_rise;

      if (!enable_in || w_enable_rise || w_timer_wrap) r_timer <= '0;
      else                                             r_timer <= r_timer + TW'(1);

      // A tick landing on the frame-start cycle queues the next frame, not an overrun
      if (!enable_in)                     r_tick_pending <= 1'b0;
      else if (w_enable_rise || w_tick)   r_tick_pending <= 1'b1;
      else if (w_start)                   r_tick_pending <= 1'b0;

      if (!enable_in)                                   r_overrun <= 1'b0;
      else if (w_tick && r_tick_pending && !w_start)    r_overrun <= 1'b1;

      if (w_start) begin
        r_swap_pending <= 1'b0;
        if (r_swap_pending || frame_swap_in) r_front <= ~r_front;
      end else if (frame_swap_in) begin
        r_swap_pending <= 1'b1;
      end

      if (w_start)                       r_idx <= '0;
      else if (w_issue && !w_last_pixel) r_idx <= r_idx + IW'(1);

      if (w_state_next != r_state)
        r_wait <= '0;
      else if ((r_state == S_FETCH) || ((r_state == S_DRAIN) && (r_wait != WW'(2))))
        r_wait <= r_wait + WW'(1);

      if (w_fetch_done) r_pixel       <= ram_data_in;
      if (w_issue)      r_drv_pixel   <= r_pixel;
      if (w_frame_done) r_frame_count <= r_frame_count + 16'd1;
    end
  end

  // Colour lines change only on an issue and then hold until the next one
  assign w_drv_pixel = w_issue ? r_pixel : r_drv_pixel;

  assign ram_rd_en_out       = w_rd_en;
  assign ram_addr_out        = {r_front, r_idx};
  assign drv_green_out       = w_drv_pixel[PW-1 -: COLOR_WIDTH];
  assign drv_red_out         = w_drv_pixel[2*COLOR_WIDTH-1 -: COLOR_WIDTH];
  assign drv_blue_out        = w_drv_pixel[COLOR_WIDTH-1:0];
  assign drv_valid_out       = w_issue;
  assign drv_force_reset_out = r_force_reset;
  assign front_buf_out       = r_front;
  assign frame_done_out      = w_frame_done;
  assign frame_count_out     = r_frame_count;
  assign frame_overrun_out   = r_overrun;

endmodule

// File: tb/tb_led_frame_scheduler.sv
// Bench for led_frame_scheduler: 4-pixel strand, 2000-cycle frames, latency-2 RAM model,
// cycle table for the first frame, directed corner cases and a randomized scoreboard phase.
module tb_led_frame_scheduler;
  localparam int NUM_LEDS = 4;
  localparam int CW       = 8;
  localparam int IW       = 2;
  localparam int PW       = 3 * CW;
  localparam int NWORDS   = 2 * (1 << IW);

  logic          clk = 1'b0;
  logic          rst_n, enable, swap, ready, idle;
  logic          rd_en, valid, force_rst, front, done, overrun;
  logic [IW:0]   addr;
  logic [PW-1:0] ram_data;
  logic [CW-1:0] g, r, b;
  logic [15:0]   count;

  always #5 clk = ~clk;

  led_frame_scheduler #(
    .NUM_LEDS(NUM_LEDS), .COLOR_WIDTH(CW), .CLOCK_SPEED(1_000_000),
    .FRAME_PERIOD_US(2000), .RAM_LATENCY(2)
  ) dut (
    .clk_in(clk), .rst_n_in(rst_n), .enable_in(enable), .frame_swap_in(swap),
    .ram_rd_en_out(rd_en), .ram_addr_out(addr), .ram_data_in(ram_data),
    .drv_green_out(g), .drv_red_out(r), .drv_blue_out(b), .drv_valid_out(valid),
    .drv_ready_in(ready), .drv_idle_in(idle), .drv_force_reset_out(force_rst),
    .front_buf_out(front), .frame_done_out(done), .frame_count_out(count),
    .frame_overrun_out(overrun)
  );

  // RAM: word appears exactly two cycles after the read strobe, junk otherwise
  logic [PW-1:0] mem [NWORDS];
  logic [PW-1:0] ram_s0, ram_s1;
  always @(posedge clk) begin
    ram_s0 <= rd_en ? mem[addr] : PW'($urandom);
    ram_s1 <= ram_s0;
  end
  assign ram_data = ram_s1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_rd(input int idx, input int limit, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(rd_en === 1'b1 && addr[IW-1:0] == IW'(idx)) && n < limit);
    check({name, "_seen"}, (rd_en === 1'b1 && addr[IW-1:0] == IW'(idx)), 1);
  endtask

  // Scoreboard: pixels of a frame are read then issued in order from one bank;
  // the bank flips at a frame start when any swap pulse arrived since the last start.
  int     sb_idx, sb_count, sb_frames;
  bit     sb_expect_rd, sb_bank, sb_swap_seen;
  longint cyc, last_valid_cyc;
  initial begin : scoreboard
    cyc = 0; last_valid_cyc = 0; sb_frames = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n !== 1'b1) begin
        sb_idx = 0; sb_count = 0; sb_expect_rd = 1; sb_bank = 0; sb_swap_seen = 0;
      end else begin
        if (rd_en === 1'b1) begin
          if (sb_idx == 0 && sb_expect_rd) begin
            sb_bank ^= sb_swap_seen;
            sb_swap_seen = 0;
            check("sb_front_buf", front, sb_bank);
          end
          check("sb_rd_order", sb_expect_rd, 1);
          check("sb_rd_addr", addr, sb_bank * (1 << IW) + sb_idx);
          sb_expect_rd = 0;
        end
        if (valid === 1'b1) begin
          check("sb_valid_order", (!sb_expect_rd && sb_idx < NUM_LEDS), 1);
          check("sb_pixel", {g, r, b}, mem[(sb_bank * (1 << IW) + sb_idx) % NWORDS]);
          sb_idx++;
          sb_expect_rd = (sb_idx < NUM_LEDS);
          last_valid_cyc = cyc;
        end
        if (done === 1'b1) begin
          check("sb_done_idx", sb_idx, NUM_LEDS);
          check("sb_drain_gap", (cyc - last_valid_cyc) >= 3, 1);
          check("sb_count", count, sb_count);
          sb_count = (sb_count + 1) & 16'hFFFF;
          sb_idx = 0;
          sb_expect_rd = 1;
          sb_frames++;
        end
        if (swap === 1'b1) sb_swap_seen = 1;
      end
    end
  end

  typedef struct {
    bit en; bit rdy; bit idl;
    bit rd; int addr; bit vld; int pix; bit dn; bit frc; int cnt;
  } vec_t;
  vec_t tbl [22];

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_addr"}, addr, 0);
    check({tag, "_valid"}, valid, 0);
    check({tag, "_pixel"}, {g, r, b}, 0);
    check({tag, "_force"}, force_rst, 0);
    check({tag, "_front"}, front, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_count"}, count, 0);
    check({tag, "_overrun"}, overrun, 0);
  endtask

  initial begin
    int saw, n_valid, n_rd, starts, frames_before;
    bit saw_done;

    for (int i = 0; i < NWORDS; i++) mem[i] = PW'($urandom);

    // First frame after enable, cycle by cycle; entry k is the k-th cycle after enable is driven
    for (int k = 0; k < 22; k++) begin
      tbl[k].en = 1; tbl[k].rdy = 1; tbl[k].idl = 1;
      tbl[k].rd = 0; tbl[k].addr = 0; tbl[k].vld = 0; tbl[k].pix = 0;
      tbl[k].dn = (k == 20); tbl[k].frc = (k == 1); tbl[k].cnt = (k >= 21) ? 1 : 0;
    end
    for (int p = 0; p < NUM_LEDS; p++) begin
      tbl[2 + 4*p].rd = 1;  tbl[2 + 4*p].addr = p;
      tbl[5 + 4*p].vld = 1; tbl[5 + 4*p].pix = p;
    end

    rst_n = 0; enable = 1; swap = 1; ready = 1; idle = 1;
    @(negedge clk); @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1; enable = 0; swap = 0;
    @(posedge clk); #1; rst_n = 1;
    repeat (3) @(posedge clk);

    for (int k = 0; k < 22; k++) begin
      @(posedge clk); #1;
      enable = tbl[k].en; ready = tbl[k].rdy; idle = tbl[k].idl;
      @(negedge clk);
      check($sformatf("vec%0d_rd_en", k), rd_en, tbl[k].rd);
      if (tbl[k].rd) check($sformatf("vec%0d_addr", k), addr, tbl[k].addr);
      check($sformatf("vec%0d_valid", k), valid, tbl[k].vld);
      if (tbl[k].vld) check($sformatf("vec%0d_pixel", k), {g, r, b}, mem[tbl[k].pix]);
      check($sformatf("vec%0d_done", k), done, tbl[k].dn);
      check($sformatf("vec%0d_force", k), force_rst, tbl[k].frc);
      check($sformatf("vec%0d_count", k), count, tbl[k].cnt);
    end

    // Frame 2: driver stalls at pixel 2, producer swaps mid-frame
    wait_rd(2, 3000, "f2_px2");
    @(posedge clk); #1; ready = 0; swap = 1;
    @(posedge clk); #1; swap = 0;
    saw = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (valid === 1'b1) saw = 1;
    end
    check("stall_no_valid", saw, 0);
    @(posedge clk); #1; ready = 1;
    @(negedge clk);
    check("stall_release_valid", valid, 1);
    check("stall_release_pixel", {g, r, b}, mem[2]);
    @(negedge clk);
    check("stall_single_pulse", valid, 0);
    check("stall_pixel_held", {g, r, b}, mem[2]);

    // Frame 3 reads the back bank
    wait_rd(0, 3000, "f3_px0");
    check("f3_addr0", addr, 4);
    check("f3_front", front, 1);
    wait_rd(3, 100, "f3_px3");
    check("f3_addr3", addr, 7);

    // Driver never reaches idle: two ticks pass with the frame still draining
    @(posedge clk); #1; idle = 0;
    for (int i = 1; i <= 5000; i++) begin
      @(negedge clk);
      if (i == 1000) check("overrun_early", overrun, 0);
      if (i == 4990) check("overrun_set", overrun, 1);
    end
    @(posedge clk); #1; idle = 1;
    starts = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (rd_en === 1'b1 && addr[IW-1:0] == '0) starts++;
    end
    check("overrun_one_start", starts, 1);
    check("overrun_sticky", overrun, 1);

    // Enable dropped during pixel 1: frame finishes, nothing follows
    wait_rd(1, 3000, "f5_px1");
    @(posedge clk); #1; enable = 0;
    n_valid = 0; saw_done = 0;
    for (int i = 0; i < 200 && !saw_done; i++) begin
      @(negedge clk);
      if (valid === 1'b1) n_valid++;
      if (done === 1'b1) saw_done = 1;
    end
    check("disable_tail_valids", n_valid, 3);
    check("disable_done", saw_done, 1);
    check("disable_overrun_clr", overrun, 0);
    n_rd = 0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (rd_en === 1'b1) n_rd++;
    end
    check("disable_no_reads", n_rd, 0);

    // Asynchronous reset while parked in ISSUE
    @(posedge clk); #1; enable = 1; ready = 0;
    wait_rd(0, 20, "rst_f_px0");
    repeat (4) @(negedge clk);
    #2; rst_n = 0; ready = 1; enable = 0;
    #1;
    check_all_zero("async_rst");
    @(posedge clk); @(posedge clk); #1; rst_n = 1;
    n_valid = 0; n_rd = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (valid === 1'b1) n_valid++;
      if (rd_en === 1'b1) n_rd++;
    end
    check("post_rst_no_valid", n_valid, 0);
    check("post_rst_no_read", n_rd, 0);
    @(posedge clk); #1; enable = 1;
    @(negedge clk);
    @(negedge clk);
    check("reenable_force", force_rst, 1);
    saw_done = 0;
    for (int i = 0; i < 100 && !saw_done; i++) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1;
    end
    check("reenable_done", saw_done, 1);
    @(negedge clk);
    check("reenable_count", count, 1);

    // Randomized traffic, all checking in the scoreboard
    frames_before = sb_frames;
    for (int i = 0; i < 16000; i++) begin
      @(posedge clk); #1;
      ready = ($urandom_range(9) < 7);
      idle  = ($urandom_range(9) < 8);
      swap  = ($urandom_range(49) == 0);
    end
    @(posedge clk); #1; ready = 1; idle = 1; swap = 0;
    repeat (100) @(negedge clk);
    check("random_progress", (sb_frames - frames_before) >= 4, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
